// File: rtl/inv_seq_ctrl_if.sv
// Handshake and status bundle shared by the ALU, the GF(2^M) inversion datapath
// and the inversion sequencer.
interface inv_seq_ctrl_if #(
  parameter int unsigned CW = 5
) ();
  logic          start;
  logic          abort;
  logic          zero_in;
  logic          mul_done;
  logic          reg_en;
  logic          reg_init;
  logic          sq_sel;
  logic          mul_start;
  logic          busy;
  logic          done;
  logic          err_zero;
  logic [CW-1:0] iter;

  // Requester side: ALU command plus multiplier completion.
  modport master (
    output start, abort, zero_in, mul_done,
    input  reg_en, reg_init, sq_sel, mul_start, busy, done, err_zero, iter
  );

  // Sequencer side.
  modport slave (
    input  start, abort, zero_in, mul_done,
    output reg_en, reg_init, sq_sel, mul_start, busy, done, err_zero, iter
  );
endinterface

// File: rtl/inv_seq_ctrl.sv
// Square-and-multiply sequencer for GF(2^M) inversion: a^-1 = a^(2^M-2) built as
// load a, (M-2) x (r^2 * a), then a final r^2.
module inv_seq_ctrl #(
  parameter int unsigned M  = 16,
  parameter int unsigned CW = 5
) (
  input logic           clk,
  input logic           rst,
  inv_seq_ctrl_if.slave bus
);

  localparam logic [CW-1:0] LAST_ITER = CW'(M - 2);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    SQ    = 3'd4,
    DONE  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] iter_q, iter_d;
  logic          zero_q, zero_d;
  logic          cap_c;

  logic reg_en_q,    reg_en_d;
  logic reg_init_q,  reg_init_d;
  logic sq_sel_q,    sq_sel_d;
  logic mul_start_q, mul_start_d;
  logic busy_q,      busy_d;
  logic done_q,      done_d;
  logic err_zero_q,  err_zero_d;

  // Next state, iteration counter and next-state output decode.
  always_comb begin
    state_d     = state_q;
    iter_d      = iter_q;
    zero_d      = zero_q;
    cap_c       = 1'b0;
    reg_en_d    = 1'b0;
    reg_init_d  = 1'b0;
    sq_sel_d    = 1'b0;
    mul_start_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    err_zero_d  = 1'b0;

    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.zero_in) begin
              state_d = DONE;
              zero_d  = 1'b1;
            end else begin
              state_d = LOAD;
              zero_d  = 1'b0;
              iter_d  = '0;
            end
          end
        end
        LOAD:  state_d = ISSUE;
        ISSUE: state_d = WAIT;
        WAIT: begin
          if (bus.mul_done) begin
            cap_c   = 1'b1;
            iter_d  = iter_q + CW'(1);
            state_d = (iter_d == LAST_ITER) ? SQ : ISSUE;
          end
        end
        SQ:      state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Moore outputs, decoded from the upcoming state so they leave flops.
    case (state_d)
      LOAD: begin
        reg_en_d   = 1'b1;
        reg_init_d = 1'b1;
        busy_d     = 1'b1;
      end
      ISSUE: begin
        mul_start_d = 1'b1;
        busy_d      = 1'b1;
      end
      WAIT: busy_d = 1'b1;
      SQ: begin
        sq_sel_d = 1'b1;
        reg_en_d = 1'b1;
        busy_d   = 1'b1;
      end
      DONE: begin
        done_d     = 1'b1;
        err_zero_d = zero_d;
        busy_d     = 1'b1;
      end
      default: ;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      iter_q      <= '0;
      zero_q      <= 1'b0;
      reg_en_q    <= 1'b0;
      reg_init_q  <= 1'b0;
      sq_sel_q    <= 1'b0;
      mul_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      zero_q      <= zero_d;
      reg_en_q    <= reg_en_d;
      reg_init_q  <= reg_init_d;
      sq_sel_q    <= sq_sel_d;
      mul_start_q <= mul_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_zero_q  <= err_zero_d;
    end
  end

  // Capture of the multiplier product happens in the mul_done cycle itself;
  // abort suppresses any register write in the cycle it is raised.
  assign bus.reg_en    = (reg_en_q | cap_c) & ~bus.abort;
  assign bus.reg_init  = reg_init_q;
  assign bus.sq_sel    = sq_sel_q;
  assign bus.mul_start = mul_start_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err_zero  = err_zero_q;
  assign bus.iter      = iter_q;

  a_no_en_with_start: assert property (@(posedge clk) disable iff (!rst)
    !(bus.reg_en && bus.mul_start));
  a_done_then_idle: assert property (@(posedge clk) disable iff (!rst)
    bus.done |=> !bus.busy);
  a_iter_bound: assert property (@(posedge clk) disable iff (!rst)
    bus.iter <= LAST_ITER);

endmodule

// File: tb/tb_inv_seq_ctrl.sv
// Self-checking bench for inv_seq_ctrl: table of whole-inversion scenarios with a
// scoreboard of expected observations, plus hand sequences for reset and idle noise.
module tb_inv_seq_ctrl;

  localparam int unsigned M    = 16;
  localparam int unsigned CW   = 5;
  localparam int          MAXC = 200;

  logic clk;
  logic rst;

  inv_seq_ctrl_if #(.CW(CW)) bus ();

  inv_seq_ctrl #(.M(M), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int lat;
    bit zero;
    int abort_iter;
    bit noise;
    int e_done;
    int e_ms;
    int e_re;
    int e_iter;
    int e_ndone;
    int e_err;
    int e_last_sq;
  } vec_t;

  vec_t tbl[8];
  int   sb[$];
  int   n_checks;
  int   n_errors;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name, input int act);
    int e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty, got %0d", name, act);
    end else begin
      e = sb.pop_front();
      check(name, act, e);
    end
  endtask

  task automatic idle_inputs();
    bus.start    = 1'b0;
    bus.zero_in  = 1'b0;
    bus.mul_done = 1'b0;
    bus.abort    = 1'b0;
  endtask

  // One inversion from start to one cycle past done/abort; cycle c follows edge c-1.
  task automatic run_vec(input vec_t v, input string tag);
    int done_cyc = 0, n_ms = 0, n_re = 0, n_done = 0, err_at_done = 0;
    int last_sq = 0, overlap = 0, bad_en = 0, spacing_bad = 0, busy_bad = 0;
    int post_bad = 0, iter_c1 = -1, iter_end = -1, last_ms = 0, due = -1;
    bit finished = 1'b0;
    bit post_seen = 1'b0;

    sb.push_back(v.e_done);
    sb.push_back(v.e_ms);
    sb.push_back(v.e_re);
    sb.push_back(v.e_iter);
    sb.push_back(v.e_ndone);
    sb.push_back(v.e_err);
    sb.push_back(v.e_last_sq);
    sb.push_back(v.zero ? v.e_iter : 0);
    sb.push_back(0);
    sb.push_back(0);
    sb.push_back(0);
    sb.push_back(0);
    sb.push_back(0);

    @(negedge clk);
    bus.start    = 1'b1;
    bus.zero_in  = v.zero;
    bus.mul_done = 1'b0;
    bus.abort    = 1'b0;

    for (int c = 1; c <= MAXC; c++) begin
      @(negedge clk);
      if (finished) begin
        idle_inputs();
        #1;
        post_bad  = int'(bus.busy) + int'(bus.done) + int'(bus.reg_en);
        iter_end  = int'(bus.iter);
        post_seen = 1'b1;
        break;
      end
      bus.start    = v.noise;
      bus.zero_in  = v.noise;
      bus.mul_done = (c == due) || (v.noise && (c % 2 == 0));
      bus.abort    = (v.abort_iter >= 0) && (n_ms == v.abort_iter + 1) && (c == last_ms + 1);
      #1;
      if (c == 1) iter_c1 = int'(bus.iter);
      if (!bus.busy) busy_bad++;
      if (bus.mul_start) begin
        if (n_ms > 0 && (c - last_ms) != v.lat + 1) spacing_bad++;
        n_ms++;
        last_ms = c;
        due     = c + v.lat;
      end
      if (bus.reg_en) begin
        n_re++;
        last_sq = int'(bus.sq_sel);
        if (bus.mul_start) overlap++;
        if (!(bus.reg_init || bus.sq_sel || bus.mul_done)) bad_en++;
      end
      if (bus.done) begin
        n_done++;
        if (done_cyc == 0) begin
          done_cyc    = c;
          err_at_done = int'(bus.err_zero);
        end
        finished = 1'b1;
      end
      if (bus.abort) finished = 1'b1;
    end
    if (!post_seen) begin
      post_bad = 1;
      idle_inputs();
    end

    sb_check({tag, ".done_cycle"}, done_cyc);
    sb_check({tag, ".mul_start_cnt"}, n_ms);
    sb_check({tag, ".reg_en_cnt"}, n_re);
    sb_check({tag, ".iter_end"}, iter_end);
    sb_check({tag, ".done_cnt"}, n_done);
    sb_check({tag, ".err_zero"}, err_at_done);
    sb_check({tag, ".last_sq_sel"}, last_sq);
    sb_check({tag, ".iter_cycle1"}, iter_c1);
    sb_check({tag, ".en_start_overlap"}, overlap);
    sb_check({tag, ".stray_reg_en"}, bad_en);
    sb_check({tag, ".ms_spacing"}, spacing_bad);
    sb_check({tag, ".busy_gap"}, busy_bad);
    sb_check({tag, ".post_idle"}, post_bad);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    //        lat zero abort noise done ms re iter ndone err lastsq
    tbl[0] = '{1, 1'b0, -1, 1'b0, 31, 14, 16, 14, 1, 0, 1};
    tbl[1] = '{4, 1'b0, -1, 1'b0, 73, 14, 16, 14, 1, 0, 1};
    tbl[2] = '{1, 1'b1, -1, 1'b0,  1,  0,  0, 14, 1, 1, 0};
    tbl[3] = '{1, 1'b0,  5, 1'b0,  0,  6,  6,  5, 0, 0, 0};
    tbl[4] = '{1, 1'b0, -1, 1'b0, 31, 14, 16, 14, 1, 0, 1};
    tbl[5] = '{1, 1'b0, -1, 1'b1, 31, 14, 16, 14, 1, 0, 1};
    tbl[6] = '{2, 1'b0, -1, 1'b0, 45, 14, 16, 14, 1, 0, 1};
    tbl[7] = '{1, 1'b1, -1, 1'b0,  1,  0,  0, 14, 1, 1, 0};

    rst = 1'b0;
    idle_inputs();
    #3;
    check("reset.outs", int'({bus.reg_en, bus.reg_init, bus.sq_sel, bus.mul_start,
                              bus.busy, bus.done, bus.err_zero}), 0);
    check("reset.iter", int'(bus.iter), 0);
    @(negedge clk);
    rst = 1'b1;

    // Multiplier completions while idle must not touch the register or counter.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.mul_done = 1'b1;
      #1;
      check($sformatf("idle_spur.reg_en%0d", i), int'(bus.reg_en), 0);
    end
    @(negedge clk);
    bus.mul_done = 1'b0;
    #1;
    check("idle_spur.busy", int'(bus.busy), 0);
    check("idle_spur.iter", int'(bus.iter), 0);

    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a WAIT after two iterations.
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      bus.start    = 1'b0;
      bus.mul_done = (c == 3) || (c == 5);
      #1;
    end
    check("rst_mid.busy_before", int'(bus.busy), 1);
    check("rst_mid.iter_before", int'(bus.iter), 2);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid.outs", int'({bus.reg_en, bus.reg_init, bus.sq_sel, bus.mul_start,
                                bus.busy, bus.done, bus.err_zero}), 0);
    check("rst_mid.iter", int'(bus.iter), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_mid.idle_busy", int'(bus.busy), 0);
    run_vec(tbl[0], "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inv_seq_ctrl.md
# inv_seq_ctrl

Sequencer for the GF(2^M) inversion generator. Computes a^-1 = a^(2^M-2) with a square-and-multiply chain: load a, apply (r^2·a) M-2 times, then a final r^2. Drives the inversion register pair (enable/init), the squarer/multiplier select and the shared multi-cycle field multiplier handshake. Produces busy/done status for the ALU.

## Interface
- M, 16: field degree; M >= 3 required.
- CW, 5: iteration counter width; 2^CW > M-2 required.

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request inversion; sampled only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE from any state
- zero_in  in  1  operand is zero; sampled with start
- mul_done  in  1  multiplier result valid; one-cycle pulse, L>=1 cycles after mul_start
- reg_en  out  1  inversion register enable
- reg_init  out  1  inversion register load of operand a (qualified by reg_en)
- sq_sel  out  1  1: register input = r^2; 0: register input = r^2·a from multiplier
- mul_start  out  1  one-cycle multiplier launch pulse
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err_zero  out  1  high with done when the operand was zero
- iter  out  CW  completed r^2·a iterations

## Operation
- States: IDLE, LOAD, ISSUE, WAIT, SQ, DONE.
- IDLE: all outputs 0 except iter (holds last value). start=1 & zero_in=0 -> LOAD, iter<=0. start=1 & zero_in=1 -> DONE with err_zero flagged; no register activity.
- LOAD (1 cycle): reg_en=1, reg_init=1 -> ISSUE.
- ISSUE (1 cycle): mul_start=1, sq_sel=0 -> WAIT.
- WAIT: sq_sel=0; holds until mul_done. In the mul_done cycle: reg_en=1, iter<=iter+1; next state SQ if iter+1 == M-2, else ISSUE.
- SQ (1 cycle): sq_sel=1, reg_en=1 -> DONE.
- DONE (1 cycle): done=1; err_zero=1 only on zero-operand path -> IDLE.
- mul_done outside WAIT: ignored, no state or output change.
- start while busy: ignored; no queuing.
- abort=1: next state IDLE, no done, no reg_en in that cycle; abort has priority over start and mul_done.
- reg_en never asserted together with mul_start.

## Timing
- Reset (rst=0, asynchronous): state IDLE; reg_en, reg_init, sq_sel, mul_start, busy, done, err_zero = 0; iter = 0.
- All outputs are registered-state decodes (Moore), except reg_en in WAIT, which is combinational from mul_done.
- start sampled at edge 0 -> LOAD in cycle 1; busy high from cycle 1.
- Each iteration takes L+1 cycles (ISSUE + L WAIT cycles, capture in the mul_done cycle).
- done asserted in cycle (M-2)(L+1)+3; busy low from the following cycle; start accepted again in that cycle.
- Zero operand: done and err_zero in cycle 1; busy high in cycle 1 only.
- Reset mid-operation: immediate return to reset values; the next start begins a fresh sequence.

## Test plan
- M=16, L=1, start with zero_in=0 -> LOAD pulse (reg_en=reg_init=1) in cycle 1; 14 mul_start pulses; done in cycle 31; iter=14; exactly 16 reg_en pulses; final reg_en has sq_sel=1.
- M=16, L=4, same stimulus -> done in cycle 73; mul_start pulses spaced 5 cycles apart; reg_en only in mul_done cycles plus LOAD and SQ.
- start with zero_in=1 -> done=err_zero=1 in cycle 1; no reg_en or mul_start; IDLE in cycle 2.
- abort in WAIT after iter=5 -> IDLE next cycle, no done, iter holds 5; a new start then yields the full 31-cycle sequence with iter reset to 0.
- Spurious mul_done in IDLE and ISSUE, plus start pulses while busy -> no extra reg_en or iter increments; done timing unchanged (cycle 31).
- rst pulled low asynchronously mid-WAIT -> all outputs 0 without a clock edge; after release, IDLE and start accepted.
